jtframe_led_pattern: RTL and testbench

- Output stage directly downstream of the system status-LED logic.
- Takes the steady LED level computed upstream and drives the physical board LED.
- Adds blink-code signalling: N pulses, a long gap, repeat, so cores can report error or status codes.
- Adds PWM brightness dimming.
- One instance per board LED, in the framework top level.

---
 rtl/jtframe_led_pattern_if.sv | 35 +++
 rtl/jtframe_led_pattern.sv | 217 +++++++++++++++++++++
 tb/tb_jtframe_led_pattern.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_led_pattern_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_led_pattern_if
//  Purpose  : Signal bundle between the status-LED logic and the LED pattern
//             output stage.
//  Signals  : led_in   - steady LED level from upstream status logic
//             code     - blink code (0 = pass-through, 1-7 = pulses/sequence)
//             code_stb - one-cycle strobe that loads code
//             dim      - PWM brightness, all-ones = full on, 0 = off
//             led_out  - registered LED drive
//             busy     - high while a blink sequence is active
//  Modports : master (upstream driver), slave (jtframe_led_pattern)
//  Revision : 1.0 - initial release
// ============================================================================
interface jtframe_led_pattern_if #(
  parameter int PWM_W = 4
) ();
  logic             led_in;
  logic [2:0]       code;
  logic             code_stb;
  logic [PWM_W-1:0] dim;
  logic             led_out;
  logic             busy;

  modport master (
    output led_in, code, code_stb, dim,
    input  led_out, busy
  );

  modport slave (
    input  led_in, code, code_stb, dim,
    output led_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_led_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_led_pattern
//  Purpose  : Board LED output stage. Passes the upstream steady LED level
//             through a PWM dimmer and, on request, replaces it with a
//             repeating blink code: N pulses, a long gap, repeat.
//  Ports    : clk    - system clock
//             rst_n  - synchronous reset, active low
//             bus    - jtframe_led_pattern_if.slave
//                      (led_in, code, code_stb, dim -> led_out, busy)
//  Options  : JTFRAME_LED_ACTLOW_EN - led_out register holds the inverted
//             level (lit = 0, reset value 1) for current-sinking LED pins.
//  Revision : 1.0 - initial release
// ============================================================================
module jtframe_led_pattern #(
  parameter int TICK_DIV  = 48000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000,
  parameter int PWM_W     = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  jtframe_led_pattern_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int c_MAX_TICKS = (c_MAX_A > GAP_TICKS) ? c_MAX_A : GAP_TICKS;
  localparam int c_TCK_W = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_TCK_W-1:0] c_ON_LAST  = c_TCK_W'(ON_TICKS - 1);
  localparam logic [c_TCK_W-1:0] c_OFF_LAST = c_TCK_W'(OFF_TICKS - 1);
  localparam logic [c_TCK_W-1:0] c_GAP_LAST = c_TCK_W'(GAP_TICKS - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ON   = 2'd1;
  localparam logic [1:0] c_ST_OFF  = 2'd2;
  localparam logic [1:0] c_ST_GAP  = 2'd3;

`ifdef JTFRAME_LED_ACTLOW_EN
  localparam logic c_LED_RST = 1'b1;
`else
  localparam logic c_LED_RST = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_TCK_W-1:0] r_tcnt;
  logic [PWM_W-1:0]   r_pwm;
  logic [2:0]         r_act;
  logic [2:0]         r_pend;
  logic               r_pend_vld;
  logic [2:0]         r_pulse;
  logic               r_led;

  logic               w_tick;
  logic               w_pwm_on;
  logic               w_on_done;
  logic               w_off_done;
  logic               w_gap_done;
  logic [2:0]         w_pulse_dec;
  logic [2:0]         w_gap_code;
  logic               w_enter_on;
  logic               w_led_lit;
  logic               w_led_nxt;
  logic               w_busy;

  // ---------------------------------------------------------------------------
  // Timing helpers
  // ---------------------------------------------------------------------------
  assign w_tick     = (r_state != c_ST_IDLE) && (r_pre == c_PRE_LAST);
  assign w_on_done  = (r_state == c_ST_ON)  && w_tick && (r_tcnt == c_ON_LAST);
  assign w_off_done = (r_state == c_ST_OFF) && w_tick && (r_tcnt == c_OFF_LAST);
  assign w_gap_done = (r_state == c_ST_GAP) && w_tick && (r_tcnt == c_GAP_LAST);
  assign w_pulse_dec = r_pulse - 3'd1;

  // Code for the next sequence at gap end. A strobe arriving on that very
  // cycle beats any stored pending code; otherwise the pending code, if one
  // was posted during the sequence, replaces the active one.
  assign w_gap_code = bus.code_stb ? bus.code :
                      (r_pend_vld ? r_pend : r_act);

  assign w_enter_on = (w_state_nxt == c_ST_ON) && (r_state != c_ST_ON);

  // Full-scale dim bypasses the comparator so the LED is steadily lit.
  assign w_pwm_on = (&bus.dim) ? 1'b1 : (r_pwm < bus.dim);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.code_stb && (bus.code != 3'd0)) begin
          w_state_nxt = c_ST_ON;
        end
      end
      c_ST_ON: begin
        if (w_on_done) begin
          w_state_nxt = (w_pulse_dec != 3'd0) ? c_ST_OFF : c_ST_GAP;
        end
      end
      c_ST_OFF: begin
        if (w_off_done) begin
          w_state_nxt = c_ST_ON;
        end
      end
      c_ST_GAP: begin
        if (w_gap_done) begin
          w_state_nxt = (w_gap_code != 3'd0) ? c_ST_ON : c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_led_lit = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      c_ST_IDLE: w_led_lit = bus.led_in & w_pwm_on;
      c_ST_ON:   w_led_lit = w_pwm_on;
      default:   w_led_lit = 1'b0;
    endcase
    w_busy = (r_state != c_ST_IDLE);
  end

`ifdef JTFRAME_LED_ACTLOW_EN
  assign w_led_nxt = ~w_led_lit;
`else
  assign w_led_nxt = w_led_lit;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: prescaler, tick counter, PWM counter, code bookkeeping, LED reg
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre      <= '0;
      r_tcnt     <= '0;
      r_pwm      <= '0;
      r_act      <= 3'd0;
      r_pend     <= 3'd0;
      r_pend_vld <= 1'b0;
      r_pulse    <= 3'd0;
      r_led      <= c_LED_RST;
    end else begin
      r_pwm <= r_pwm + PWM_W'(1);
      r_led <= w_led_nxt;

      // Prescaler is held in IDLE and restarted on every ON entry so each
      // pulse is a whole number of ticks long.
      if ((r_state == c_ST_IDLE) || w_enter_on) begin
        r_pre <= '0;
      end else if (r_pre == c_PRE_LAST) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + c_PRE_W'(1);
      end

      if (w_state_nxt != r_state) begin
        r_tcnt <= '0;
      end else if (w_tick) begin
        r_tcnt <= r_tcnt + c_TCK_W'(1);
      end

      // Code and pulse bookkeeping
      if ((r_state == c_ST_IDLE) && bus.code_stb && (bus.code != 3'd0)) begin
        r_act   <= bus.code;
        r_pulse <= bus.code;
      end else if (w_on_done) begin
        r_pulse <= w_pulse_dec;
      end else if (w_gap_done) begin
        r_act   <= w_gap_code;
        r_pulse <= w_gap_code;
      end

      // Strobes during a sequence are parked until gap end; last one wins.
      if (w_gap_done) begin
        r_pend     <= 3'd0;
        r_pend_vld <= 1'b0;
      end else if ((r_state != c_ST_IDLE) && bus.code_stb) begin
        r_pend     <= bus.code;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign bus.led_out = r_led;
  assign bus.busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_led_pattern.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_led_pattern
//  Purpose  : Self-checking bench for jtframe_led_pattern with TICK_DIV=4,
//             ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=5 (8/8/20 clk windows).
//             Honours JTFRAME_LED_ACTLOW_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_led_pattern;
  localparam int PWM_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  jtframe_led_pattern_if #(.PWM_W(PWM_W)) bus ();

  jtframe_led_pattern #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(2),
    .GAP_TICKS(5),
    .PWM_W    (PWM_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic  led;
    logic  busy;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Physical pin level for a logical "lit" value
  function automatic logic lv(input logic lit);
`ifdef JTFRAME_LED_ACTLOW_EN
    return ~lit;
`else
    return lit;
`endif
  endfunction

  task automatic check_bit(input logic obs, input logic expv, input string tag);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input int obs, input int expv, input string tag);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Push the expected result of the upcoming edge, clock, then pop and compare.
  task automatic cyc(input logic lit, input logic busy, input string tag);
    exp_t e;
    e.led  = lv(lit);
    e.busy = busy;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_bit(bus.led_out, e.led,  {e.tag, ".led"});
    check_bit(bus.busy,    e.busy, {e.tag, ".busy"});
  endtask

  task automatic run(input logic lit, input int n, input logic busy, input string tag);
    for (int i = 0; i < n; i++) cyc(lit, busy, tag);
  endtask

  task automatic strobe(input logic [2:0] c, input logic lit, input logic busy,
                        input string tag);
    bus.code     = c;
    bus.code_stb = 1'b1;
    cyc(lit, busy, tag);
    bus.code_stb = 1'b0;
  endtask

  task automatic skip();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    int         cnt;

    rst_n        = 1'b0;
    bus.led_in   = 1'b0;
    bus.code     = 3'd0;
    bus.code_stb = 1'b0;
    bus.dim      = '1;
    #1;

    // Reset holds led_out dark regardless of led_in
    for (int i = 0; i < 4; i++) begin
      bus.led_in = i[0];
      cyc(1'b0, 1'b0, "reset");
    end

    // IDLE pass-through, one clock latency at full brightness
    rst_n = 1'b1;
    pat   = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      bus.led_in = pat[i];
      cyc(pat[i], 1'b0, "follow");
    end

    // PWM: dim=4 lights 4 of every 16 clocks
    bus.led_in = 1'b1;
    bus.dim    = 4'd4;
    skip();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      skip();
      if (bus.led_out === lv(1'b1)) cnt++;
    end
    check_int(cnt, 8, "pwm_dim4_lit_count");

    // dim=0 keeps the LED dark
    bus.dim = 4'd0;
    skip();
    run(1'b0, 16, 1'b0, "dim0");

    // Code 3: three 8-clk pulses separated by 8-clk gaps, then 20 clks dark
    bus.dim    = '1;
    bus.led_in = 1'b0;
    skip();
    strobe(3'd3, 1'b0, 1'b1, "c3_start");
    run(1'b1, 8,  1'b1, "c3_p1");
    run(1'b0, 8,  1'b1, "c3_off1");
    run(1'b1, 8,  1'b1, "c3_p2");
    run(1'b0, 8,  1'b1, "c3_off2");
    run(1'b1, 8,  1'b1, "c3_p3");
    run(1'b0, 20, 1'b1, "c3_gap");
    // Second round; code 1 posted during pulse 2 must not truncate it
    run(1'b1, 8,  1'b1, "r2_p1");
    run(1'b0, 8,  1'b1, "r2_off1");
    run(1'b1, 4,  1'b1, "r2_p2a");
    strobe(3'd1, 1'b1, 1'b1, "r2_stb1");
    run(1'b1, 3,  1'b1, "r2_p2b");
    run(1'b0, 8,  1'b1, "r2_off2");
    run(1'b1, 8,  1'b1, "r2_p3");
    run(1'b0, 20, 1'b1, "r2_gap");
    // Single-pulse sequences follow
    run(1'b1, 8,  1'b1, "c1_p");
    run(1'b0, 20, 1'b1, "c1_gap");
    run(1'b1, 2,  1'b1, "c1_p2a");
    strobe(3'd0, 1'b1, 1'b1, "c1_stb0");
    run(1'b1, 5,  1'b1, "c1_p2b");
    run(1'b0, 19, 1'b1, "c0_gap");
    cyc(1'b0, 1'b0, "c0_idle");
    bus.led_in = 1'b1;
    cyc(1'b1, 1'b0, "track1");
    bus.led_in = 1'b0;
    cyc(1'b0, 1'b0, "track0");

    // Reset mid-ON aborts immediately and stays idle afterwards
    strobe(3'd2, 1'b0, 1'b1, "c2_start");
    run(1'b1, 3, 1'b1, "c2_p1");
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, "rst_mid_on");
    rst_n      = 1'b1;
    bus.led_in = 1'b1;
    run(1'b1, 30, 1'b0, "post_rst_idle");

    // Strobe on the final gap cycle overrides the stored pending code
    bus.led_in = 1'b0;
    skip();
    strobe(3'd2, 1'b0, 1'b1, "c2b_start");
    run(1'b1, 4,  1'b1, "c2b_p1a");
    strobe(3'd3, 1'b1, 1'b1, "c2b_pend3");
    run(1'b1, 3,  1'b1, "c2b_p1b");
    run(1'b0, 8,  1'b1, "c2b_off1");
    run(1'b1, 8,  1'b1, "c2b_p2");
    run(1'b0, 19, 1'b1, "c2b_gap");
    strobe(3'd1, 1'b0, 1'b1, "gap_end_stb1");
    run(1'b1, 8,  1'b1, "new1_p");
    run(1'b0, 20, 1'b1, "new1_gap");
    run(1'b1, 4,  1'b1, "new1_p2a");
    strobe(3'd0, 1'b1, 1'b1, "new1_stb0");
    run(1'b1, 3,  1'b1, "new1_p2b");
    run(1'b0, 19, 1'b1, "new1_gap2");
    cyc(1'b0, 1'b0, "back_idle");

    // code=0 strobe in IDLE is ignored
    strobe(3'd0, 1'b0, 1'b0, "zero_ignored");
    run(1'b0, 5, 1'b0, "idle_stays");

    check_int(sb.size(), 0, "scoreboard_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
